// File: rtl/reg_bus_master.sv
// reg_bus_master: bus initiator for the register bank CS / RD_WR / shared-data bus.
// Runs READ, WRITE, MOVE and NOP commands and returns a one-cycle response strobe.
module reg_bus_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr_a,
    input  logic [ADDR_WIDTH-1:0] req_addr_b,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  CS,
    output logic                  RD_WR,
    output logic [ADDR_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0] data
);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_MOVE  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_CAP,
        TURN,
        WR
    } state_t;

    state_t                state;
    logic [1:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_b_q;
    logic [DATA_WIDTH-1:0] rbuf;
    logic [DATA_WIDTH-1:0] dout;
    logic                  drive;

    // The data bus is only ever driven from the registered WR-state enable.
    assign data = drive ? dout : {DATA_WIDTH{1'bz}};

    // Commands are taken only while idle and out of reset.
    assign req_ready = reset && (state == IDLE);

    // Command sequencer: state, bus outputs and response are all registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            op_q      <= OP_NOP;
            addr_b_q  <= '0;
            rbuf      <= '0;
            dout      <= '0;
            drive     <= 1'b0;
            CS        <= 1'b0;
            RD_WR     <= 1'b1;
            address   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        addr_b_q <= req_addr_b;
                        unique case (1'b1)
                            (req_op == OP_NOP): begin
                                rsp_valid <= 1'b1;
                                rsp_rdata <= '0;
                            end
                            (req_op == OP_WRITE): begin
                                state   <= WR;
                                CS      <= 1'b1;
                                RD_WR   <= 1'b0;
                                address <= req_addr_a;
                                dout    <= req_wdata;
                                drive   <= 1'b1;
                            end
                            (req_op == OP_READ),
                            (req_op == OP_MOVE): begin
                                state   <= RD_ADDR;
                                CS      <= 1'b1;
                                RD_WR   <= 1'b1;
                                address <= req_addr_a;
                            end
                            default: begin
                                state <= IDLE;
                            end
                        endcase
                    end
                end
                RD_ADDR: begin
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    // Bank has driven data since the RD_ADDR edge; grab it now.
                    state <= TURN;
                    CS    <= 1'b0;
                    rbuf  <= data;
                    if (op_q == OP_READ) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= data;
                    end
                end
                TURN: begin
                    // Bank releases data at the end of this cycle, so WR may follow.
                    if (op_q == OP_MOVE) begin
                        state   <= WR;
                        CS      <= 1'b1;
                        RD_WR   <= 1'b0;
                        address <= addr_b_q;
                        dout    <= rbuf;
                        drive   <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                WR: begin
                    state     <= IDLE;
                    CS        <= 1'b0;
                    RD_WR     <= 1'b1;
                    drive     <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= (op_q == OP_MOVE) ? rbuf : '0;
                end
                default: begin
                    state <= IDLE;
                    CS    <= 1'b0;
                    RD_WR <= 1'b1;
                    drive <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master: directed and random commands against a behavioural bank model.
// A simple registered bank drives the shared bus; a reference array predicts results.
module tb_reg_bus_master;

    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] READ  = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;
    localparam logic [1:0] MOVE  = 2'b11;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [2:0] req_addr_a;
    logic [2:0] req_addr_b;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       CS;
    logic       RD_WR;
    logic [2:0] address;
    wire  [7:0] data;

    int errors;
    int checks;

    logic [7:0] ref_mem [8];
    logic [7:0] last_rd;

    // bank model
    logic [7:0] bank [8];
    logic       slave_en;
    logic [7:0] slave_val;

    reg_bus_master #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr_a (req_addr_a),
        .req_addr_b (req_addr_b),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .CS         (CS),
        .RD_WR      (RD_WR),
        .address    (address),
        .data       (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered bank: drives data the cycle after it sees a read select.
    always @(posedge clk) begin
        slave_en  <= CS && RD_WR;
        slave_val <= bank[address];
        if (CS && !RD_WR) bank[address] <= data;
    end

    assign data = slave_en ? slave_val : 8'bz;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Master must never drive while the bank is driving.
    always @(negedge clk) begin
        if (slave_en === 1'b1)
            chk("contention", {31'd0, CS === 1'b1 && RD_WR === 1'b0}, 32'd0);
    end

    task automatic garbage();
        req_valid  = 1'b0;
        req_op     = 2'($urandom);
        req_addr_a = 3'($urandom);
        req_addr_b = 3'($urandom);
        req_wdata  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            garbage();
            chk("idle_rsp_valid", rsp_valid, 0);
            chk("idle_rdata_hold", rsp_rdata, last_rd);
            chk("idle_cs", CS, 0);
        end
    endtask

    // Issue one command at a negedge and check every cycle up to its response.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] a,
                           input logic [2:0] b, input logic [7:0] wd,
                           input bit coincide);
        int         lat;
        int         waitc;
        logic [7:0] exp_rd;
        logic       e_cs;
        logic       e_rw;
        bit         c_addr;
        logic [2:0] e_addr;
        bit         c_data;
        logic [7:0] e_data;
        case (op)
            NOP: begin lat = 1; exp_rd = 8'h00; end
            WRITE: begin lat = 2; exp_rd = 8'h00; ref_mem[a] = wd; end
            READ: begin lat = 3; exp_rd = ref_mem[a]; end
            default: begin
                lat = 5;
                exp_rd = ref_mem[a];
                ref_mem[b] = exp_rd;
            end
        endcase
        req_valid  = 1'b1;
        req_op     = op;
        req_addr_a = a;
        req_addr_b = b;
        req_wdata  = wd;
        if (coincide) begin
            chk("coincide_rsp", rsp_valid, 1);
            chk("coincide_ready", req_ready, 1);
        end
        waitc = 0;
        while (req_ready !== 1'b1 && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        if (req_ready !== 1'b1) begin
            chk("accept_timeout", req_ready, 1);
            garbage();
            return;
        end
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            garbage();
            e_cs = 1'b0; e_rw = 1'b1;
            c_addr = 0; e_addr = a;
            c_data = 0; e_data = wd;
            case (op)
                WRITE: if (k == 1) begin
                    e_cs = 1'b1; e_rw = 1'b0;
                    c_addr = 1; c_data = 1;
                end
                READ: if (k <= 2) begin
                    e_cs = 1'b1; c_addr = 1;
                end
                MOVE: begin
                    if (k <= 2) begin
                        e_cs = 1'b1; c_addr = 1;
                    end else if (k == 4) begin
                        e_cs = 1'b1; e_rw = 1'b0;
                        c_addr = 1; e_addr = b;
                        c_data = 1; e_data = exp_rd;
                    end
                end
                default: ;
            endcase
            chk($sformatf("cs op%0d k%0d", op, k), CS, e_cs);
            chk($sformatf("rdwr op%0d k%0d", op, k), RD_WR, e_rw);
            if (c_addr)
                chk($sformatf("addr op%0d k%0d", op, k), address, e_addr);
            if (c_data)
                chk($sformatf("data op%0d k%0d", op, k), data, e_data);
            chk($sformatf("rsp_valid op%0d k%0d", op, k), rsp_valid, k == lat);
            if (k == lat) begin
                chk($sformatf("rdata op%0d", op), rsp_rdata, exp_rd);
                last_rd = exp_rd;
                if (op == READ) chk("ready_in_turn", req_ready, 0);
            end
        end
    endtask

    initial begin
        logic [1:0] op;
        logic [1:0] prev_op;
        logic [2:0] a;
        logic [2:0] b;
        bit         co;
        errors  = 0;
        checks  = 0;
        last_rd = 8'h00;
        reset   = 1'b0;
        garbage();

        // reset held two clocks
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", CS, 0);
        chk("rst_rdwr", RD_WR, 1);
        chk("rst_addr", address, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", req_ready, 1);

        // fill bank through the bus
        for (int i = 0; i < 8; i++)
            run_cmd(WRITE, 3'(i), 3'd0, 8'($urandom), i > 0);

        run_cmd(WRITE, 3'd5, 3'd0, 8'hA5, 1);
        run_cmd(READ, 3'd5, 3'd0, 8'h00, 1);
        run_cmd(MOVE, 3'd5, 3'd2, 8'h00, 0);
        run_cmd(READ, 3'd2, 3'd0, 8'h00, 1);
        run_cmd(READ, 3'd3, 3'd0, 8'h00, 0);
        run_cmd(WRITE, 3'd6, 3'd0, 8'h5A, 0);
        run_cmd(NOP, 3'd0, 3'd0, 8'h00, 1);
        run_cmd(MOVE, 3'd4, 3'd4, 8'h00, 1);
        run_cmd(READ, 3'd4, 3'd0, 8'h00, 1);
        idle(2);

        // reset during RD_CAP of a MOVE aborts it
        run_cmd(WRITE, 3'd1, 3'd0, 8'h3C, 0);
        run_cmd(WRITE, 3'd6, 3'd0, 8'hC3, 1);
        req_valid  = 1'b1;
        req_op     = MOVE;
        req_addr_a = 3'd1;
        req_addr_b = 3'd6;
        chk("abort_ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        garbage();
        chk("abort_rdaddr_cs", CS, 1);
        @(negedge clk);
        chk("abort_rdcap_cs", CS, 1);
        chk("abort_rdcap_rdwr", RD_WR, 1);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_cs", CS, 0);
            chk("abort_rdwr", RD_WR, 1);
            chk("abort_rsp_valid", rsp_valid, 0);
            chk("abort_ready", req_ready, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("post_abort_rsp_valid", rsp_valid, 0);
        chk("post_abort_rdata", rsp_rdata, 0);
        chk("post_abort_ready", req_ready, 1);
        chk("post_abort_cs", CS, 0);
        last_rd = 8'h00;
        run_cmd(READ, 3'd6, 3'd0, 8'h00, 0);
        prev_op = READ;

        // random traffic
        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = 3'($urandom_range(0, 7));
            b  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                idle(int'($urandom_range(1, 3)));
                co = 0;
            end else begin
                co = (prev_op == NOP) || (prev_op == WRITE);
            end
            run_cmd(op, a, b, 8'($urandom), co);
            prev_op = op;
        end

        // read back the whole bank
        for (int i = 0; i < 8; i++)
            run_cmd(READ, 3'(i), 3'd0, 8'h00, 0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
